// File: rtl/g_word_engine.sv
// -----------------------------------------------------------------------------
// g_word_engine
//
// AES key-schedule word function with a serialised S-box stage.
//   mode = 0 : g(w) = SubWord(RotWord(w)) ^ {Rcon[roundNum], 24'h0}
//   mode = 1 : h(w) = SubWord(w)  (AES-256 step where i mod 8 == 4)
// The four byte substitutions are spread over SUB_CYCLES = 4/SBOX_LANES
// clock cycles, using SBOX_LANES copies of the forward S-box ROM.
// Only one request is in flight at a time.
//
// Ports
//   clk        in   1   system clock, rising edge
//   n_rst      in   1   synchronous reset, ACTIVE-HIGH (1 = reset)
//   enable     in   1   request strobe, accepted only while idle
//   mode       in   1   0 = g function, 1 = h function
//   inputVal   in  32   word w, byte 3 = [31:24]
//   roundNum   in   4   Rcon index (ignored when mode = 1)
//   outputVal  out 32   result, updated only on completion and held
//   done       out  1   one-cycle completion pulse
//   busy       out  1   high while a request is being processed
//
// Handshake: a request is taken on a rising edge where enable = 1 and the
// engine is idle (busy = 0). Requests arriving while busy = 1 are dropped,
// not queued. done pulses for one cycle with outputVal valid in that same
// cycle; enable may be high in the done cycle and is then accepted.
// -----------------------------------------------------------------------------
module g_word_engine #(
    parameter int SBOX_LANES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        enable,
    input  logic        mode,
    input  logic [31:0] inputVal,
    input  logic [3:0]  roundNum,
    output logic [31:0] outputVal,
    output logic        done,
    output logic        busy
);

    localparam int SUB_CYCLES = 4 / SBOX_LANES;
    localparam int LANE_SHIFT = (SBOX_LANES == 4) ? 2 : ((SBOX_LANES == 2) ? 1 : 0);
    localparam logic [1:0] LAST_CNT = 2'(SUB_CYCLES - 1);

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
            $error("g_word_engine: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    // FIPS-197 forward S-box, row = high nibble, column = low nibble.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SUB  = 1'b1
    } state_t;

    // Round constant; indices outside 1..10 yield zero without any flag.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] work_q,  work_d;
    logic [7:0]  rcon_q,  rcon_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] out_q,   out_d;
    logic        done_q,  done_d;
    logic        busy_q,  busy_d;

    logic [31:0] sub_word;
    logic [1:0]  lane_idx;

    // Substitution datapath: SBOX_LANES lookups per cycle. Step k covers
    // byte lanes 3-k*L down to 4-(k+1)*L, so the word is consumed MSB-first.
    // For L = 4 the counter is always 0 and the shifted term vanishes.
    always_comb begin
        sub_word = work_q;
        lane_idx = 2'd0;
        for (int j = 0; j < SBOX_LANES; j++) begin
            lane_idx = 2'd3 - (cnt_q << LANE_SHIFT) - 2'(j);
            sub_word[{lane_idx, 3'b000} +: 8] = SBOX[work_q[{lane_idx, 3'b000} +: 8]];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    // Rotation is applied at capture so SUB sees a plain word.
                    work_d  = mode ? inputVal : {inputVal[23:0], inputVal[31:24]};
                    rcon_d  = mode ? 8'h00 : rcon_of(roundNum);
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                work_d = sub_word;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    // Only the finished word reaches outputVal.
                    out_d   = sub_word ^ {rcon_q, 24'h000000};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= ST_IDLE;
            work_q  <= 32'h0;
            rcon_q  <= 8'h00;
            cnt_q   <= 2'd0;
            out_q   <= 32'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign outputVal = out_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_g_word_engine.sv
// -----------------------------------------------------------------------------
// tb_g_word_engine
//
// Three engines (SBOX_LANES = 1, 2, 4) share mode/inputVal/roundNum and reset
// but each has its own enable. A transaction-level model predicts, per
// engine, outputVal/done/busy every cycle: the result word comes from AES
// math (S-box derived from the GF(2^8) inverse plus affine map, Rcon by
// repeated xtime) and appears SUB_CYCLES edges after acceptance.
// -----------------------------------------------------------------------------
module tb_g_word_engine;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [2:0]  en = 3'b000;
    logic        mode = 1'b0;
    logic [31:0] in_val = 32'h0;
    logic [3:0]  round_num = 4'd0;
    logic [31:0] out_val [3];
    logic [2:0]  done_v;
    logic [2:0]  busy_v;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        g_word_engine #(.SBOX_LANES(1 << gi)) u_dut (
            .clk      (clk),
            .n_rst    (n_rst),
            .enable   (en[gi]),
            .mode     (mode),
            .inputVal (in_val),
            .roundNum (round_num),
            .outputVal(out_val[gi]),
            .done     (done_v[gi]),
            .busy     (busy_v[gi])
        );
    end

    // ---------------- reference math ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] rcon_m(input logic [3:0] r);
        logic [7:0] c = 8'h01;
        if (r == 4'd0 || r > 4'd10) return 8'h00;
        for (int k = 1; k < int'(r); k++) c = xtime(c);
        return c;
    endfunction

    function automatic logic [31:0] ref_fn(input logic md, input logic [31:0] w,
                                           input logic [3:0] r);
        logic [31:0] x;
        logic [31:0] s;
        x = md ? w : {w[23:0], w[31:24]};
        for (int b = 0; b < 4; b++) s[b*8 +: 8] = sbox_m[x[b*8 +: 8]];
        if (!md) s = s ^ {rcon_m(r), 24'h0};
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-engine transaction model ----------------
    bit          m_busy [3] = '{0, 0, 0};
    bit          m_done [3] = '{0, 0, 0};
    int          m_left [3] = '{0, 0, 0};
    logic [31:0] m_res  [3] = '{0, 0, 0};
    logic [31:0] m_out  [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (n_rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_left[i] = 0;
                m_out[i]  = 32'h0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_out[i]  = m_res[i];
                        m_done[i] = 1'b1;
                        m_busy[i] = 1'b0;
                    end
                end else if (en[i]) begin
                    m_res[i]  = ref_fn(mode, in_val, round_num);
                    m_left[i] = 4 >> i;
                    m_busy[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc_out_L%0d", 1 << i), out_val[i], m_out[i]);
                chk($sformatf("cyc_done_L%0d", 1 << i), 32'(done_v[i]), 32'(m_done[i]));
                chk($sformatf("cyc_busy_L%0d", 1 << i), 32'(busy_v[i]), 32'(m_busy[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge with engine i idle; returns at the negedge where
    // done is seen (or after the bound expires).
    task automatic run_req(input int i, input logic md, input logic [31:0] w,
                           input logic [3:0] r, input logic [31:0] exp, input string name);
        int n;
        mode = md; in_val = w; round_num = r; en[i] = 1'b1;
        @(negedge clk);
        en[i] = 1'b0;
        n = 1;
        while (!done_v[i] && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[i]) begin
            total++; bad++;
            $display("FAIL %s_L%0d: no done within %0d cycles", name, 1 << i, n);
        end else begin
            chk($sformatf("%s_L%0d", name, 1 << i), out_val[i], exp);
            chk($sformatf("%s_lat_L%0d", name, 1 << i), 32'(n), 32'((4 >> i) + 1));
        end
    endtask

    task automatic busy_scenario(input int i);
        int n;
        mode = 1'b0; in_val = 32'h0; round_num = 4'd4; en[i] = 1'b1;
        @(negedge clk);
        chk($sformatf("busy_set_L%0d", 1 << i), 32'(busy_v[i]), 32'd1);
        in_val = 32'hFFFFFFFF; round_num = 4'd1;   // dropped: engine is busy
        n = 1;
        while (n < 12) begin
            @(negedge clk);
            n++;
            en[i] = 1'b0;
            if (done_v[i]) break;
        end
        if (!done_v[i]) begin
            total++; bad++;
            $display("FAIL busy_done_L%0d: no done within %0d cycles", 1 << i, n);
        end else begin
            chk($sformatf("busy_out_L%0d", 1 << i), out_val[i], 32'h6B636363);
            chk($sformatf("busy_lat_L%0d", 1 << i), 32'(n), 32'((4 >> i) + 1));
            // Request raised in the done cycle must be accepted.
            in_val = 32'hAAAAAAAA; round_num = 4'd1; en[i] = 1'b1;
            @(negedge clk);
            en[i] = 1'b0;
            chk($sformatf("done_cycle_accept_L%0d", 1 << i), 32'(busy_v[i]), 32'd1);
            n = 1;
            while (!done_v[i] && n < 12) begin
                @(negedge clk);
                n++;
            end
            if (!done_v[i]) begin
                total++; bad++;
                $display("FAIL b2b_done_L%0d: no done within %0d cycles", 1 << i, n);
            end else begin
                chk($sformatf("b2b_out_L%0d", 1 << i), out_val[i], 32'hADACACAC);
            end
        end
    endtask

    task automatic reset_scenario();
        bit seen_done = 1'b0;
        mode = 1'b0; in_val = 32'h09CF4F3C; round_num = 4'd1; en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (2) @(negedge clk);                 // two SUB edges taken
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        chk("midrst_out", out_val[0], 32'h0);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_v[0]) seen_done = 1'b1;
        end
        chk("midrst_no_done", 32'(seen_done), 32'd0);
        chk("midrst_out_hold", out_val[0], 32'h0);
        run_req(0, 1'b0, 32'hAAAAAAAA, 4'd1, 32'hADACACAC, "post_rst");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        build_sbox();

        // Literal anchors for the model itself.
        chk("model_g_aa",   ref_fn(1'b0, 32'hAAAAAAAA, 4'd1),  32'hADACACAC);
        chk("model_g_fips", ref_fn(1'b0, 32'h09CF4F3C, 4'd1),  32'h8B84EB01);
        chk("model_g_r10",  ref_fn(1'b0, 32'h00000000, 4'd10), 32'h55636363);
        chk("model_h_1234", ref_fn(1'b1, 32'h12345678, 4'd7),  32'hC918B1BC);

        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_L%0d", 1 << i), out_val[i], 32'h0);
            chk($sformatf("rst_done_L%0d", 1 << i), 32'(done_v[i]), 32'd0);
            chk($sformatf("rst_busy_L%0d", 1 << i), 32'(busy_v[i]), 32'd0);
        end
        check_on = 1'b1;
        n_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run_req(i, 1'b0, 32'hAAAAAAAA, 4'd1,  32'hADACACAC, "g_aa");
            run_req(i, 1'b0, 32'h09CF4F3C, 4'd1,  32'h8B84EB01, "g_fips");
            run_req(i, 1'b0, 32'h00000000, 4'd10, 32'h55636363, "g_r10");
            run_req(i, 1'b0, 32'h00000000, 4'd0,  32'h63636363, "g_r0");
            run_req(i, 1'b1, 32'hFFFFFFFF, 4'd7,  32'h16161616, "h_ff");
            run_req(i, 1'b1, 32'h12345678, 4'd7,  32'hC918B1BC, "h_1234");
            busy_scenario(i);
            repeat (2) @(negedge clk);
        end

        reset_scenario();

        // Random traffic on all three engines, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) en[i] = ($urandom_range(0, 2) == 0);
            mode      = 1'($urandom_range(0, 1));
            in_val    = $urandom;
            round_num = 4'($urandom_range(0, 15));
            n_rst     = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        en = 3'b000;
        n_rst = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
